req_ack_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single req/ack handshake resource among NUM_REQ requesters. It grants one requester at a time and drives the resource request. It waits for the resource acknowledge, with a timeout, and reports per-requester completion or error pulses. It sits between requesting agents and a req/ack responder such as our handshake generator blocks.

---
 rtl/req_ack_arbiter.sv | 93 +++++++++
 tb/tb_req_ack_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter that lends one shared req/ack resource to NUM_REQ requesters,
// with an acknowledge timeout and per-requester done/err completion pulses.
module req_ack_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 8,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               res_ack,
  output logic               res_req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] sel_reg;
  logic [IDX_W-1:0] sel_next;
  logic [IDX_W-1:0] cand;

  // Walk downward so the last hit is the first set bit above the pointer.
  always_comb begin
    sel_next = ptr_reg;
    cand     = ptr_reg;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((32'(ptr_reg) + 32'(i)) % 32'(NUM_REQ));
      if (req_in[cand]) sel_next = cand;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
      sel_reg   <= '0;
      res_req   <= 1'b0;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      busy      <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_in) begin
            sel_reg   <= sel_next;
            grant     <= NUM_REQ'(1) << sel_next;
            res_req   <= 1'b1;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          // An ack on the threshold cycle still counts as success.
          if (res_ack) begin
            res_req   <= 1'b0;
            done      <= grant;
            ptr_reg   <= sel_reg;
            state_reg <= RELEASE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            res_req   <= 1'b0;
            err       <= grant;
            ptr_reg   <= sel_reg;
            state_reg <= RELEASE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          if (!res_ack) begin
            grant     <= '0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Scoreboard bench for req_ack_arbiter: a driver plays requesters and responder and
// queues expected outcomes; a negedge monitor checks every completion and invariant.
module tb_req_ack_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req_in = '0;
  logic         res_ack = 1'b0;
  logic         res_req;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic [N-1:0] err;
  logic         busy;

  req_ack_arbiter #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req_in  (req_in),
    .res_ack (res_ack),
    .res_req (res_req),
    .grant   (grant),
    .done    (done),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    bit           ok;
    int           req_cycles;
    int           busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   last_served = N - 1;
  int   txn_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Priority order: the requester after the one served last, wrapping around.
  function automatic int pick(input int last, input logic [N-1:0] p);
    logic [N-1:0] mask;
    for (int k = 1; k <= N; k++) begin
      mask = N'(1) << ((last + k) % N);
      if ((p & mask) != 0) return (last + k) % N;
    end
    return -1;
  endfunction

  // One transaction: p requests, the responder acks in REQ cycle d for h cycles
  // (no ack at all when d >= TIMEOUT). Called at a negedge with the DUT idle.
  task automatic run_txn(input logic [N-1:0] p, input int d, input int h);
    exp_t e;
    int   w;
    int   ack_left;
    bit   ended;
    w             = pick(last_served, p);
    last_served   = w;
    e.gnt         = N'(1) << w;
    e.ok          = (d < TIMEOUT);
    e.req_cycles  = e.ok ? d + 1 : TIMEOUT;
    e.busy_cycles = e.req_cycles + (e.ok ? h : 1);
    exp_q.push_back(e);
    req_in  = p;
    res_ack = 1'b0;
    @(negedge clk);
    check("grant_latency", 32'(res_req), 32'd1);
    ack_left = 0;
    ended    = 1'b0;
    for (int c = 0; c < 64 && !ended; c++) begin
      if (c > 0 && !busy) begin
        ended = 1'b1;
      end else begin
        req_in = res_req ? N'($urandom) : '0;
        if (c == d && e.ok) ack_left = h;
        res_ack = (ack_left > 0);
        if (ack_left > 0) ack_left--;
        @(negedge clk);
      end
    end
    check("txn_bounded", 32'(ended), 32'd1);
    req_in  = '0;
    res_ack = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each done/err pulse.
  initial begin
    exp_t cur;
    bit   have_cur;
    int   req_cnt;
    int   busy_cnt;
    have_cur = 1'b0;
    req_cnt  = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        have_cur = 1'b0;
        req_cnt  = 0;
        busy_cnt = 0;
      end else begin
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("done_err_exclusive", 32'(done & err), 32'd0);
        check("pulse_on_grant", 32'((done | err) & ~grant), 32'd0);
        check("busy_matches_grant", 32'(busy), 32'(grant != '0));
        if (res_req) req_cnt++;
        if (busy) busy_cnt++;
        if (done != '0 || err != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({done, err}), 32'd0);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            txn_count++;
            $display("txn %0d grant=%b done=%b err=%b req_cycles=%0d", txn_count, grant, done, err, req_cnt);
            check("grant", 32'(grant), 32'(cur.gnt));
            check("done", 32'(done), cur.ok ? 32'(cur.gnt) : 32'd0);
            check("err", 32'(err), cur.ok ? 32'd0 : 32'(cur.gnt));
            check("req_cycles", 32'(req_cnt), 32'(cur.req_cycles));
          end
          req_cnt = 0;
        end
        if (!busy && busy_cnt > 0) begin
          if (have_cur) check("busy_cycles", 32'(busy_cnt), 32'(cur.busy_cycles));
          else check("busy_without_completion", 32'(busy_cnt), 32'd0);
          have_cur = 1'b0;
          busy_cnt = 0;
          req_cnt  = 0;
        end
      end
    end
  end

  initial begin
    int gap;
    #1;
    check("reset_state", 32'({res_req, grant, done, err, busy}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({res_req, grant, done, err, busy}), 32'd0);

    // Directed: single requester, round robin, timeout, threshold ack, sticky ack.
    run_txn(4'b0001, 1, 1);
    for (int r = 0; r < 5; r++) run_txn(4'b1111, 1, 1);
    run_txn(4'b0100, TIMEOUT + 1, 1);
    run_txn(4'b0110, 2, 1);
    run_txn(4'b1000, TIMEOUT - 1, 1);
    run_txn(4'b0001, 0, 6);
    run_txn(4'b0011, 0, 1);

    // Reset in the middle of a REQ phase aborts silently.
    req_in = 4'b0001;
    @(negedge clk);
    req_in = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_clears", 32'({res_req, grant, done, err, busy}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n     = 1'b1;
    last_served = N - 1;
    run_txn(4'b1010, 2, 1);

    for (int t = 0; t < 150; t++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        req_in  = '0;
        res_ack = 1'($urandom);
        @(negedge clk);
        check("idle_quiet", 32'({res_req, grant}), 32'd0);
      end
      res_ack = 1'b0;
      run_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, TIMEOUT + 1)),
              int'($urandom_range(1, 4)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
